fir_sample_buffer: RTL
======================

FIR_SAMPLE_BUFFER -- requirements
Module: fir_sample_buffer

Interface
REQ-001 Parameter ADDR_W, default 7, sample-memory address width; depth is 2^ADDR_W.
REQ-002 Parameter DATA_W, default 16, sample and result width.
REQ-003 Parameter TAPS, default 32, filter window length; legal range 2..2^ADDR_W.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low (0 = in reset).
REQ-006 in_valid  in  1  upstream audio sample valid.
REQ-007 in_ready  out  1  block accepts a sample.
REQ-008 in_sample  in  DATA_W  incoming audio sample.
REQ-009 fir_start  out  1  one-cycle pulse that launches the downstream FIR.
REQ-010 fir_start_addr  out  ADDR_W  oldest sample address of the window.
REQ-011 fir_last_addr  out  ADDR_W  newest sample address of the window.
REQ-012 fir_audio_addr  in  ADDR_W  FIR read address.
REQ-013 fir_audio_data  out  DATA_W  sample at fir_audio_addr, registered.
REQ-014 fir_done  in  1  FIR completion flag.
REQ-015 fir_result  in  DATA_W  FIR output, valid while fir_done=1.
REQ-016 out_valid  out  1  filtered sample valid.
REQ-017 out_ready  in  1  downstream accepts the filtered sample.
REQ-018 out_sample  out  DATA_W  filtered sample.

Function
REQ-019 Storage is 2^ADDR_W x DATA_W, one write port and one synchronous read port.
REQ-020 fir_audio_data SHALL equal mem[fir_audio_addr] one cycle after the address is applied, in every state.
REQ-021 FSM states: IDLE, START, RUN, OUT.
REQ-022 IDLE: in_ready=1; on in_valid&in_ready, write in_sample to mem[wp] and increment wp modulo 2^ADDR_W.
REQ-023 The fill counter increments per accepted sample and saturates at TAPS.
REQ-024 IDLE->START on an accepted sample once the fill count (including that sample) reaches TAPS; otherwise stay IDLE and produce no output.
REQ-025 Window registers: fir_last_addr = address just written; fir_start_addr = (that address - (TAPS-1)) mod 2^ADDR_W; both held stable from START until the next window.
REQ-026 With wrap-around, fir_start_addr > fir_last_addr; the window is the ascending address range modulo 2^ADDR_W.
REQ-027 START: fir_start=1 for exactly one cycle; go to RUN.
REQ-028 RUN: ignore fir_done in the first RUN cycle (stale done); thereafter, on fir_done=1, capture fir_result into out_sample and go to OUT.
REQ-029 OUT: out_valid=1, out_sample stable until out_valid&out_ready, then IDLE next cycle.
REQ-030 in_ready=0 in START, RUN and OUT; back-pressure only, no samples dropped.
REQ-031 No memory write occurs outside IDLE, so no read/write collision exists.

Reset
REQ-032 While reset=0: in_ready=0, fir_start=0, out_valid=0, out_sample=0, fir_start_addr=0, fir_last_addr=0, fir_audio_data=0, wp=0, fill count=0, state=IDLE.
REQ-033 Reset asserted in any state aborts the operation immediately; the warm-up of TAPS samples is required again; memory contents are not cleared.
REQ-034 in_ready rises in the first cycle after reset deasserts.

Structure
REQ-035 Shared package fir_pkg holds the ADDR_W/DATA_W defaults and the FSM state enum, shared with fir_filter.
REQ-036 One sub-module, sample_ram (1 write port, 1 synchronous read port, no reset), holds storage.

Verification
REQ-037 Warm-up: TAPS=3, push 2,3 -> no fir_start; push 6 -> one-cycle fir_start, fir_start_addr=0, fir_last_addr=2.
REQ-038 Read port: after the above, fir_audio_addr=1 -> fir_audio_data=3 next cycle; addr=2 -> 6.
REQ-039 Result path: fir_done=1, fir_result=5 -> out_valid=1, out_sample=5; out_ready low 10 cycles -> held stable, in_ready=0; out_ready=1 -> IDLE, in_ready=1.
REQ-040 Wrap: ADDR_W=2, TAPS=3, push 6 samples -> 6th window fir_start_addr=3, fir_last_addr=1.
REQ-041 Stale done: fir_done held 1 across START -> no capture in first RUN cycle; capture in second.
REQ-042 Reset mid-RUN: reset=0 -> out_valid=0, in_ready=0 immediately; after release, two pushes give no fir_start, third gives fir_start.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR sample buffer and the downstream FIR filter.
// Holds the default memory geometry and the buffer FSM state encoding so both
// blocks agree on widths and can decode the exposed state.
package fir_pkg;

    localparam int ADDR_W_DEF = 7;   // sample-memory address width
    localparam int DATA_W_DEF = 16;  // sample / result width
    localparam int TAPS_DEF   = 32;  // filter window length

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // accepting samples
        START = 2'd1,   // one-cycle launch of the FIR
        RUN   = 2'd2,   // FIR is walking the window
        OUT   = 2'd3    // holding the filtered sample for downstream
    } fir_state_t;

endpackage

// File: rtl/fir_sample_buffer_sample_ram.sv
// sample_ram: 2^ADDR_W x DATA_W storage with one write port and one
// synchronous read port. No reset: contents survive a block reset.
//
// Ports:
//   clk      rising-edge clock
//   wr_en    write strobe
//   wr_addr  write address
//   wr_data  write data
//   rd_addr  read address, sampled every cycle
//   rd_data  mem[rd_addr] registered one cycle after rd_addr is applied
module sample_ram #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/fir_sample_buffer.sv
// fir_sample_buffer: circular audio sample store feeding a downstream FIR.
// Samples are accepted in IDLE and written at the write pointer. Once TAPS
// samples have been collected, every accepted sample opens a window of the
// last TAPS addresses, pulses fir_start, waits for fir_done and presents the
// FIR result downstream.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holds valid and its data stable until that edge; the
// consumer may raise or drop ready freely.
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   in_valid/in_ready   upstream sample handshake, in_sample data
//   fir_start           one-cycle FIR launch pulse
//   fir_start_addr      oldest sample address of the window
//   fir_last_addr       newest sample address of the window
//   fir_audio_addr      FIR read address; fir_audio_data is the registered read
//   fir_done/fir_result FIR completion and result
//   out_valid/out_ready downstream handshake, out_sample data
//   fsm_state           current FSM state, for observation
module fir_sample_buffer
    import fir_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int TAPS   = TAPS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_sample,
    output logic              fir_start,
    output logic [ADDR_W-1:0] fir_start_addr,
    output logic [ADDR_W-1:0] fir_last_addr,
    input  logic [ADDR_W-1:0] fir_audio_addr,
    output logic [DATA_W-1:0] fir_audio_data,
    input  logic              fir_done,
    input  logic [DATA_W-1:0] fir_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sample,
    output fir_state_t        fsm_state
);

    // Fill count needs one extra bit so TAPS = 2^ADDR_W is representable.
    localparam logic [ADDR_W:0]   TAPS_C = (ADDR_W+1)'(TAPS);
    localparam logic [ADDR_W-1:0] SPAN   = ADDR_W'(TAPS - 1);

    fir_state_t        state, next_state;
    logic [ADDR_W-1:0] wp;
    logic [ADDR_W:0]   fill;
    logic [ADDR_W:0]   fill_inc;
    logic              run_first;
    logic              accept;
    logic              window;
    logic              capture;
    logic [DATA_W-1:0] ram_q;

    assign fsm_state = state;

    // Saturating fill count including the sample being accepted now.
    assign fill_inc = (fill == TAPS_C) ? fill : fill + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        fir_start  = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        window     = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                // Gated by reset so in_ready is low while reset is held even
                // though the state register already sits in IDLE.
                in_ready = reset;
                accept   = in_valid & reset;
                if (accept && (fill_inc == TAPS_C)) begin
                    window     = 1'b1;
                    next_state = START;
                end
            end
            START: begin
                fir_start  = 1'b1;
                next_state = RUN;
            end
            RUN: begin
                // The first RUN cycle may still see fir_done from the
                // previous window; only trust it afterwards.
                if (!run_first && fir_done) begin
                    capture    = 1'b1;
                    next_state = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp             <= '0;
            fill           <= '0;
            fir_start_addr <= '0;
            fir_last_addr  <= '0;
            out_sample     <= '0;
            run_first      <= 1'b0;
        end else begin
            if (accept) begin
                wp   <= wp + 1'b1;
                fill <= fill_inc;
            end
            if (window) begin
                fir_last_addr  <= wp;
                fir_start_addr <= wp - SPAN;
            end
            if (state == START) begin
                run_first <= 1'b1;
            end else if (state == RUN) begin
                run_first <= 1'b0;
            end
            if (capture) begin
                out_sample <= fir_result;
            end
        end
    end

    sample_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (wp),
        .wr_data (in_sample),
        .rd_addr (fir_audio_addr),
        .rd_data (ram_q)
    );

    // The RAM read register has no reset; force the visible read data to
    // zero while reset is held.
    assign fir_audio_data = reset ? ram_q : '0;

endmodule
